mq_byteout: RTL and testbench
=============================

Name: mq_byteout

Overview:
- BYTEOUT and FLUSH engine of the MQ arithmetic encoder.
- Upstream of the output/pointer stage. Consumes the C register whenever renormalisation exhausts CT.
- Handles carry propagation into the held byte B and bit stuffing after 0xFF. Returns the updated C/CT to the coder.
- Emits finalised codestream bytes on a valid/ready byte stream with a running byte count.

Parameters:
- CW, 28, width of C register
- CNTW, 16, width of emitted-byte counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- init  in  1  start new codeword: B=0x00, first=1, byte_cnt=0
- bo_req  in  1  one-cycle BYTEOUT request; accepted only when bo_ready=1
- flush_req  in  1  one-cycle flush request (caller has already done SETBITS); accepted only when bo_ready=1
- c_in  in  CW  C register value for bo_req/flush_req
- ct_in  in  4  CT value for flush_req
- bo_ready  out  1  engine idle and output register free (or draining this cycle)
- bo_done  out  1  one-cycle pulse; c_out/ct_out valid
- c_out  out  CW  updated C after BYTEOUT
- ct_out  out  4  updated CT (7 or 8)
- byte_valid  out  1  byte_data holds a finalised byte
- byte_data  out  8  codestream byte
- byte_ready  in  1  downstream accepts byte when byte_valid&byte_ready
- byte_cnt  out  CNTW  bytes accepted downstream since init; wraps modulo 2^CNTW
- flush_done  out  1  one-cycle pulse at end of flush

Behaviour:
- Reset values:
  - B=0, first=1, all pulses 0, byte_valid=0, byte_data=0, byte_cnt=0, c_out=0, ct_out=0, FSM=IDLE.
- Precedence:
  - rst over init.
  - init over bo_req/flush_req; a request in the init cycle is dropped.
  - bo_req with flush_req together: flush_req ignored.
- BYTEOUT (accepted cycle N; results registered, visible at N+1 with bo_done=1). "Emit" means load old B into the output register, unless first=1, in which case the byte is discarded and first is cleared.
  - If B==0xFF:
    - emit B.
    - B = C[27:20], C &= 0xFFFFF, CT=7.
  - Else if C[27]==0:
    - emit B.
    - B = C[26:19], C &= 0x7FFFF, CT=8.
  - Else (carry): B = B+1 (8-bit).
    - If the result is 0xFF: emit 0xFF; C &= 0x7FFFFFF; B = C[27:20]; C &= 0xFFFFF; CT=7.
    - Otherwise: emit B+1; B = C[26:19] (bit 27 discarded); C &= 0x7FFFF; CT=8.
- Output register:
  - Single entry.
  - byte_data is stable while byte_valid=1 and byte_ready=0.
  - byte_cnt increments on each handshake.
- Backpressure:
  - bo_ready = (FSM==IDLE) & (!byte_valid | byte_ready).
  - Requests arriving while bo_ready=0 are ignored; the caller must hold off.
- Flush FSM:
  - States: IDLE -> FS1 -> FB1 -> FS2 -> FB2 -> FLAST -> IDLE.
  - FSn: C = (C << CT) truncated to CW bits.
  - FBn: BYTEOUT as above, updating internal C/CT. FBn waits while the output register is full and byte_ready=0.
  - FLAST: if B != 0xFF, emit B (waits for output register free); a trailing 0xFF is discarded.
  - flush_done pulses on FLAST exit. bo_done is not pulsed during flush.
  - After flush, first=1 and B=0. The next codeword needs no init, but init is permitted.
- Mid-operation reset or init:
  - FSM returns to IDLE.
  - Output register is cleared; any pending byte is lost.
  - No pulse is generated.

Decomposition:
- Shared package mq_pkg, holding:
  - C width constant.
  - Masks 0x7FFFFFF, 0xFFFFF, 0x7FFFF.
  - CT reload constants 7 and 8.
  - Flush state enum.
- One natural sub-module, mq_byte_reg: the single-entry valid/ready output register with byte counter.

Test Plan:
- init; bo_req c_in=0x1234567 -> N+1: bo_done, c_out=0x0034567, ct_out=8, no byte (first); held B=0x24.
- Then bo_req c_in=0x8000000 -> byte 0x25 emitted, c_out=0, ct_out=8, held B=0x00, byte_cnt=1 after handshake.
- init; bo_req 0x7F00000 (B=0xFE); bo_req 0x8A00000 -> emit 0xFF, ct_out=7, c_out=0, held B=0x0A.
- init; bo_req 0x7F80000 (B=0xFF); bo_req 0x0345678 -> emit 0xFF, held B=0x03, c_out=0x45678, ct_out=7.
- B=0x12 held; flush_req c_in=0, ct_in=8 -> bytes 0x12, 0x00, 0x00 in order; flush_done once; byte_cnt +3.
- byte_ready=0 with a byte pending -> bo_ready=0, byte_data stable, second bo_req ignored. Raising byte_ready -> handshake, bo_ready=1 the next cycle.

Source files
------------

// File: rtl/mq_pkg.sv
// Shared constants, flush state encoding and the BYTEOUT step used by the MQ byte-output engine.
package mq_pkg;

    localparam int unsigned C_W = 28;

    localparam logic [C_W-1:0] MASK27 = 28'h7FF_FFFF;
    localparam logic [C_W-1:0] MASK20 = 28'h00F_FFFF;
    localparam logic [C_W-1:0] MASK19 = 28'h007_FFFF;

    localparam logic [3:0] CT_STUFF = 4'd7;
    localparam logic [3:0] CT_PLAIN = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FS1,
        ST_FB1,
        ST_FS2,
        ST_FB2,
        ST_FLAST
    } flush_state_t;

    typedef struct packed {
        logic [7:0]     b;
        logic [C_W-1:0] c;
        logic [3:0]     ct;
        logic [7:0]     emit;
    } bo_res_t;

    // One BYTEOUT step: next held byte, next C/CT, and the byte that leaves B.
    function automatic bo_res_t byteout(input logic [7:0] b, input logic [C_W-1:0] c);
        bo_res_t        r;
        logic [7:0]     inc;
        logic [C_W-1:0] cm;
        inc    = b + 8'd1;
        cm     = c & MASK27;
        r.emit = b;
        r.b    = c[26:19];
        r.c    = c & MASK19;
        r.ct   = CT_PLAIN;
        if (b == 8'hFF) begin
            r.b  = c[27:20];
            r.c  = c & MASK20;
            r.ct = CT_STUFF;
        end else if (c[27]) begin
            // Carry into B; a carry that produces 0xFF forces a stuffed byte next.
            r.emit = inc;
            if (inc == 8'hFF) begin
                r.b  = cm[27:20];
                r.c  = cm & MASK20;
                r.ct = CT_STUFF;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mq_byte_reg.sv
// Single-entry valid/ready output register with a handshake counter.
module mq_byte_reg
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [7:0]      load_data,
    input  logic            byte_ready,
    output logic            byte_valid,
    output logic [7:0]      byte_data,
    output logic [CNTW-1:0] byte_cnt,
    output logic            free
);

    assign free = !byte_valid || byte_ready;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_cnt   <= '0;
        end else begin
            if (byte_valid && byte_ready) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (load) begin
                byte_valid <= 1'b1;
                byte_data  <= load_data;
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mq_byteout.sv
// MQ encoder BYTEOUT/FLUSH engine: carry propagation into B, bit stuffing, byte emission.
module mq_byteout
    import mq_pkg::*;
#(
    parameter int unsigned CW   = 28,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            bo_req,
    input  logic            flush_req,
    input  logic [CW-1:0]   c_in,
    input  logic [3:0]      ct_in,
    output logic            bo_ready,
    output logic            bo_done,
    output logic [CW-1:0]   c_out,
    output logic [3:0]      ct_out,
    output logic            byte_valid,
    output logic [7:0]      byte_data,
    input  logic            byte_ready,
    output logic [CNTW-1:0] byte_cnt,
    output logic            flush_done
);

    flush_state_t  state;
    logic [7:0]    b;
    logic          first;
    logic [CW-1:0] c_reg;
    logic [3:0]    ct_reg;
    logic          out_free;
    logic          load;
    logic [7:0]    load_data;
    bo_res_t       res;

    assign bo_ready = (state == ST_IDLE) && out_free;

    always_comb begin
        res       = byteout(b, (state == ST_IDLE) ? c_in : c_reg);
        load      = 1'b0;
        load_data = res.emit;
        case (state)
            ST_IDLE:        load = bo_req && out_free && !first;
            ST_FB1, ST_FB2: load = out_free && !first;
            ST_FLAST: begin
                load      = out_free && (b != 8'hFF);
                load_data = b;
            end
            default:        load = 1'b0;
        endcase
        if (init) begin
            load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        bo_done    <= 1'b0;
        flush_done <= 1'b0;
        if (rst) begin
            state  <= ST_IDLE;
            b      <= '0;
            first  <= 1'b1;
            c_reg  <= '0;
            ct_reg <= '0;
            c_out  <= '0;
            ct_out <= '0;
        end else if (init) begin
            state <= ST_IDLE;
            b     <= '0;
            first <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bo_ready && bo_req) begin
                        b       <= res.b;
                        c_out   <= res.c;
                        ct_out  <= res.ct;
                        first   <= 1'b0;
                        bo_done <= 1'b1;
                    end else if (bo_ready && flush_req) begin
                        c_reg  <= c_in;
                        ct_reg <= ct_in;
                        state  <= ST_FS1;
                    end
                end
                ST_FS1, ST_FS2: begin
                    c_reg <= c_reg << ct_reg;
                    state <= (state == ST_FS1) ? ST_FB1 : ST_FB2;
                end
                ST_FB1, ST_FB2: begin
                    if (out_free) begin
                        b      <= res.b;
                        c_reg  <= res.c;
                        ct_reg <= res.ct;
                        first  <= 1'b0;
                        state  <= (state == ST_FB1) ? ST_FS2 : ST_FLAST;
                    end
                end
                ST_FLAST: begin
                    // A trailing 0xFF is dropped, so it never waits on the output register.
                    if (out_free || (b == 8'hFF)) begin
                        b          <= '0;
                        first      <= 1'b1;
                        flush_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mq_byte_reg #(
        .CNTW (CNTW)
    ) u_byte_reg (
        .clk        (clk),
        .rst        (rst),
        .clr        (init),
        .load       (load),
        .load_data  (load_data),
        .byte_ready (byte_ready),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_cnt   (byte_cnt),
        .free       (out_free)
    );

endmodule

// File: tb/tb_mq_byteout.sv
// Scoreboard bench for mq_byteout: arithmetic reference model feeds queues, a negedge monitor checks them.
module tb_mq_byteout;

    localparam longint unsigned P19 = 64'd524288;
    localparam longint unsigned P20 = 64'd1048576;
    localparam longint unsigned P27 = 64'd134217728;
    localparam longint unsigned P28 = 64'd268435456;

    logic        clk = 1'b0;
    logic        rst, init, bo_req, flush_req, byte_ready;
    logic [27:0] c_in;
    logic [3:0]  ct_in;
    logic        bo_ready, bo_done, byte_valid, flush_done;
    logic [27:0] c_out;
    logic [3:0]  ct_out;
    logic [7:0]  byte_data;
    logic [15:0] byte_cnt;

    always #5 clk = ~clk;

    mq_byteout #(
        .CW   (28),
        .CNTW (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .bo_req     (bo_req),
        .flush_req  (flush_req),
        .c_in       (c_in),
        .ct_in      (ct_in),
        .bo_ready   (bo_ready),
        .bo_done    (bo_done),
        .c_out      (c_out),
        .ct_out     (ct_out),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .byte_cnt   (byte_cnt),
        .flush_done (flush_done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_mode = 1;
    logic [7:0]  exp_bytes[$];
    logic [27:0] exp_c[$];
    logic [3:0]  exp_ct[$];
    int          exp_flush = 0;
    logic [15:0] exp_cnt = '0;
    int unsigned m_b = 0;
    bit          m_first = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Reference model: integer arithmetic on B, C and the first-byte flag.
    task automatic m_emit(input int unsigned v);
        if (m_first) m_first = 1'b0;
        else exp_bytes.push_back(8'(v));
    endtask

    task automatic m_byteout(inout longint unsigned c, output int unsigned ct);
        if (m_b == 255) begin
            m_emit(m_b);
            m_b = int'((c / P20) % 256);
            c   = c % P20;
            ct  = 7;
        end else if (c < P27) begin
            m_emit(m_b);
            m_b = int'((c / P19) % 256);
            c   = c % P19;
            ct  = 8;
        end else begin
            m_b = (m_b + 1) % 256;
            if (m_b == 255) begin
                m_emit(255);
                c   = c % P27;
                m_b = int'((c / P20) % 256);
                c   = c % P20;
                ct  = 7;
            end else begin
                m_emit(m_b);
                m_b = int'((c / P19) % 256);
                c   = c % P19;
                ct  = 8;
            end
        end
    endtask

    task automatic m_flush(input longint unsigned c0, input int unsigned ct0);
        longint unsigned c;
        int unsigned     ct;
        c  = c0;
        ct = ct0;
        for (int i = 0; i < 2; i++) begin
            c = (c << ct) % P28;
            m_byteout(c, ct);
        end
        if (m_b != 255) m_emit(m_b);
        m_first = 1'b1;
        m_b     = 0;
        exp_flush++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bo_req    = 1'b0;
        flush_req = 1'b0;
        init      = 1'b0;
        if (rdy_mode == 2) byte_ready = ($urandom_range(0, 3) != 0);
        else               byte_ready = (rdy_mode == 1);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bo_ready) begin
            cyc();
            n++;
            if (n > 200) begin
                timeout("wait_bo_ready");
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (byte_valid || !bo_ready) begin
            cyc();
            n++;
            if (n > 200) begin
                timeout("wait_idle");
                break;
            end
        end
    endtask

    task automatic do_bo(input logic [27:0] c, input logic with_flush);
        longint unsigned lc;
        int unsigned     ct;
        wait_ready();
        bo_req    = 1'b1;
        flush_req = with_flush;
        c_in      = c;
        ct_in     = 4'($urandom_range(0, 15));
        lc        = longint'(c);
        m_byteout(lc, ct);
        exp_c.push_back(28'(lc));
        exp_ct.push_back(4'(ct));
        cyc();
    endtask

    task automatic do_flush(input logic [27:0] c, input logic [3:0] ct);
        wait_ready();
        flush_req = 1'b1;
        c_in      = c;
        ct_in     = ct;
        m_flush(longint'(c), int'(ct));
        cyc();
    endtask

    task automatic do_init(input logic with_req);
        wait_idle();
        init   = 1'b1;
        bo_req = with_req;
        c_in   = 28'($urandom);
        m_b     = 0;
        m_first = 1'b1;
        cyc();
    endtask

    function automatic logic [27:0] rnd_c();
        logic [27:0] c;
        c = 28'($urandom);
        if ($urandom_range(0, 3) == 0) c |= 28'h7F80000;
        return c;
    endfunction

    // Monitor: values seen at negedge are those the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = '0;
        end else begin
            if (bo_done) begin
                if (exp_c.size() == 0) begin
                    timeout("unexpected_bo_done");
                end else begin
                    check("c_out", 32'(c_out), 32'(exp_c.pop_front()));
                    check("ct_out", 32'(ct_out), 32'(exp_ct.pop_front()));
                end
            end
            if (flush_done) begin
                check("flush_done_expected", 32'(exp_flush > 0), 32'd1);
                if (exp_flush > 0) exp_flush--;
            end
            if (byte_valid && byte_ready) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_byte", 32'(byte_data), 32'hFFFF_FFFF);
                end else begin
                    check("byte_data", 32'(byte_data), 32'(exp_bytes.pop_front()));
                end
                check("byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
            if (init) exp_cnt = '0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pend;
        rst = 1'b1; init = 1'b0; bo_req = 1'b0; flush_req = 1'b0;
        c_in = '0; ct_in = '0; byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ct_out", 32'(ct_out), 32'd0);
        check("rst_pulses", 32'({bo_done, flush_done}), 32'd0);
        check("rst_bo_ready", 32'(bo_ready), 32'd1);
        rst = 1'b0;
        rdy_mode = 1;
        cyc();

        // Plain byte, then a carry into the held byte.
        do_init(1'b0);
        do_bo(28'h1234567, 1'b0);
        do_bo(28'h8000000, 1'b0);
        wait_idle();
        check("cnt_after_first", 32'(byte_cnt), 32'd1);

        // Carry turning B into 0xFF.
        do_init(1'b0);
        do_bo(28'h7F00000, 1'b0);
        do_bo(28'h8A00000, 1'b0);

        // Held 0xFF forces a 7-bit byte.
        do_init(1'b0);
        do_bo(28'h7F80000, 1'b0);
        do_bo(28'h0345678, 1'b0);

        // Flush from held B=0x12.
        do_init(1'b0);
        do_bo(28'h0900000, 1'b0);
        do_flush(28'h0000000, 4'd8);
        wait_idle();
        check("cnt_after_flush", 32'(byte_cnt), 32'd3);

        // Backpressure: pending byte holds, extra requests ignored.
        rdy_mode = 0;
        do_bo(rnd_c(), 1'b0);
        do_bo(rnd_c(), 1'b0);
        pend = exp_bytes[exp_bytes.size() - 1];
        for (int i = 0; i < 3; i++) begin
            check("bp_bo_ready", 32'(bo_ready), 32'd0);
            check("bp_byte_valid", 32'(byte_valid), 32'd1);
            check("bp_byte_data", 32'(byte_data), 32'(pend));
            bo_req = 1'b1;
            c_in   = 28'($urandom);
            cyc();
        end
        rdy_mode = 1;
        cyc();
        cyc();
        check("drain_bo_ready", 32'(bo_ready), 32'd1);
        check("drain_byte_valid", 32'(byte_valid), 32'd0);

        // Simultaneous bo_req/flush_req acts as bo_req; init drops a same-cycle request.
        do_bo(rnd_c(), 1'b1);
        do_init(1'b1);

        // Randomised traffic.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            op = $urandom_range(0, 99);
            if (op < 70)      do_bo(rnd_c(), 1'b0);
            else if (op < 85) do_flush(rnd_c(), 4'($urandom_range(0, 15)));
            else if (op < 95) do_init(1'b0);
            else if (op < 98) do_init(1'b1);
            else              do_bo(rnd_c(), 1'b1);
        end
        rdy_mode = 1;
        wait_idle();
        repeat (4) cyc();

        // Reset while a flush is stalled on backpressure.
        do_init(1'b0);
        rdy_mode = 0;
        do_flush(28'h0000000, 4'd8);
        repeat (8) cyc();
        rst = 1'b1;
        exp_bytes.delete();
        exp_c.delete();
        exp_ct.delete();
        exp_flush = 0;
        m_b = 0;
        m_first = 1'b1;
        cyc();
        check("midrst_byte_valid", 32'(byte_valid), 32'd0);
        check("midrst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("midrst_bo_ready", 32'(bo_ready), 32'd1);
        check("midrst_flush_done", 32'(flush_done), 32'd0);
        rst = 1'b0;
        rdy_mode = 1;
        cyc();
        do_bo(rnd_c(), 1'b0);
        do_bo(rnd_c(), 1'b0);
        wait_idle();
        repeat (4) cyc();

        check("left_bytes", 32'(exp_bytes.size()), 32'd0);
        check("left_bo_done", 32'(exp_c.size()), 32'd0);
        check("left_flush", 32'(exp_flush), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
